// File: rtl/reset_seq.sv
// Multi-domain reset sequencer: synchronized PLL lock and debounced pushbutton gate a
// hold phase, then per-domain resets release in staggered order. Soft reset: RESET_SEQ_SWRST_EN.
module reset_seq #(
  parameter int NCH         = 2,
  parameter int HOLD_CYCLES = 255,
  parameter int STAGGER     = 16,
  parameter int DEBOUNCE    = 1000
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           PLL_LOCKED,
  input  logic           BTN_RST,
  input  logic [NCH-1:0] SW_RST_REQ,
  output logic [NCH-1:0] RSTn,
  output logic           READY,
  output logic [1:0]     CAUSE
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;

  state_t          state;
  logic            lock_s1, lock_s2, btn_s1, btn_s2;
  logic            btn_db;
  logic [DW-1:0]   db_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [SW-1:0]   stag_cnt;
  logic [NCH-1:0]  rel_mask;
  logic            fault;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
    end else begin
      lock_s1 <= PLL_LOCKED;
      lock_s2 <= lock_s1;
      btn_s1  <= BTN_RST;
      btn_s2  <= btn_s1;
    end
  end

  // The debounced level only follows the synced button after an unbroken run of mismatches.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s2 != btn_db) begin
      if (db_cnt == DW'(DEBOUNCE - 1)) begin
        btn_db <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign fault = !lock_s2 || btn_db;

`ifdef RESET_SEQ_SWRST_EN
  logic [NCH-1:0] soft_act, soft_act_n;
  logic [HW-1:0]  soft_cnt   [NCH];
  logic [HW-1:0]  soft_cnt_n [NCH];

  always_comb begin
    soft_act_n = soft_act;
    for (int k = 0; k < NCH; k++) begin
      soft_cnt_n[k] = soft_cnt[k];
      if (SW_RST_REQ[k]) begin
        soft_act_n[k] = 1'b1;
        soft_cnt_n[k] = HW'(HOLD_CYCLES - 1);
      end else if (soft_act[k]) begin
        if (soft_cnt[k] == '0) soft_act_n[k] = 1'b0;
        else soft_cnt_n[k] = soft_cnt[k] - HW'(1);
      end
    end
  end

  // Soft state only advances in an undisturbed RUN; anything else clears it.
  always_ff @(posedge CLK) begin
    if (RESET || fault || state != RUN) begin
      soft_act <= '0;
      for (int k = 0; k < NCH; k++) soft_cnt[k] <= '0;
    end else begin
      soft_act <= soft_act_n;
      for (int k = 0; k < NCH; k++) soft_cnt[k] <= soft_cnt_n[k];
    end
  end
`else
  logic unused_sw;
  assign unused_sw = ^SW_RST_REQ;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ASSERT;
      RSTn     <= '0;
      READY    <= 1'b0;
      CAUSE    <= 2'b01;
      hold_cnt <= HW'(HOLD_CYCLES);
      stag_cnt <= '0;
      rel_mask <= '0;
    end else if (fault) begin
      if (state != ASSERT) CAUSE <= lock_s2 ? 2'b11 : 2'b10;
      state    <= ASSERT;
      RSTn     <= '0;
      READY    <= 1'b0;
      hold_cnt <= HW'(HOLD_CYCLES);
    end else begin
      case (state)
        ASSERT: begin
          if (hold_cnt == '0) begin
            RSTn     <= NCH'(1);
            stag_cnt <= SW'(STAGGER - 1);
            rel_mask <= NCH'(2);
            if (NCH == 1) begin
              state <= RUN;
              READY <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        // rel_mask is one-hot on the next channel to come out of reset.
        RELEASE: begin
          if (stag_cnt == '0) begin
            RSTn     <= RSTn | rel_mask;
            stag_cnt <= SW'(STAGGER - 1);
            if (rel_mask[NCH-1]) begin
              state <= RUN;
              READY <= 1'b1;
            end else begin
              rel_mask <= rel_mask << 1;
            end
          end else begin
            stag_cnt <= stag_cnt - SW'(1);
          end
        end
        RUN: begin
`ifdef RESET_SEQ_SWRST_EN
          RSTn  <= ~soft_act_n;
          READY <= ~|soft_act_n;
`endif
        end
        default: state <= ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq (NCH=2, HOLD_CYCLES=4, STAGGER=3, DEBOUNCE=5): a cycle table
// for the full sequence, lock loss, button and RESET cases, plus soft-reset sequences.
module tb_reset_seq;

  localparam int NCH = 2;
`ifdef RESET_SEQ_SWRST_EN
  localparam bit SWEN = 1'b1;
`else
  localparam bit SWEN = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic           PLL_LOCKED = 1'b0;
  logic           BTN_RST = 1'b0;
  logic [NCH-1:0] SW_RST_REQ = '0;
  logic [NCH-1:0] RSTn;
  logic           READY;
  logic [1:0]     CAUSE;

  int tests = 0;
  int fails = 0;

  reset_seq #(.NCH(NCH), .HOLD_CYCLES(4), .STAGGER(3), .DEBOUNCE(5)) dut (
    .CLK(CLK), .RESET(RESET), .PLL_LOCKED(PLL_LOCKED), .BTN_RST(BTN_RST),
    .SW_RST_REQ(SW_RST_REQ), .RSTn(RSTn), .READY(READY), .CAUSE(CAUSE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       lock;
    logic       btn;
    logic [1:0] rstn;
    logic       ready;
    logic [1:0] cause;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst, input logic lock, input logic btn,
                        input logic [1:0] rstn, input logic ready,
                        input logic [1:0] cause, input int n);
    vec_t v;
    v.rst = rst; v.lock = lock; v.btn = btn;
    v.rstn = rstn; v.ready = ready; v.cause = cause;
    repeat (n) vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic lock, input logic btn,
                               input logic [1:0] sw);
    @(negedge CLK);
    RESET = rst;
    PLL_LOCKED = lock;
    BTN_RST = btn;
    SW_RST_REQ = sw;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] er,
                             input logic ey, input logic [1:0] ec);
    tests++;
    if (RSTn !== er || READY !== ey || CAUSE !== ec) begin
      fails++;
      $display("[TB] FAIL %s: got RSTn=%b READY=%b CAUSE=%b, expected RSTn=%b READY=%b CAUSE=%b",
               name, RSTn, READY, CAUSE, er, ey, ec);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic low;
    logic [1:0] sw;

    // rst lock btn | RSTn READY CAUSE | cycles
    addVec(1, 0, 0, 2'b00, 0, 2'b01, 1);
    addVec(1, 1, 0, 2'b00, 0, 2'b01, 1);
    addVec(0, 1, 0, 2'b00, 0, 2'b01, 6);   // first lock sample e: hold phase
    addVec(0, 1, 0, 2'b01, 0, 2'b01, 3);   // RSTn[0] at e+6
    addVec(0, 1, 0, 2'b11, 1, 2'b01, 2);   // RSTn[1], READY at e+9
    addVec(0, 0, 0, 2'b11, 1, 2'b01, 1);   // one-cycle lock drop
    addVec(0, 1, 0, 2'b11, 1, 2'b01, 1);
    addVec(0, 1, 0, 2'b00, 0, 2'b10, 5);   // two edges after sampling
    addVec(0, 1, 0, 2'b01, 0, 2'b10, 3);
    addVec(0, 1, 0, 2'b11, 1, 2'b10, 1);
    addVec(0, 1, 1, 2'b11, 1, 2'b10, 4);   // 4-cycle button: filtered out
    addVec(0, 1, 0, 2'b11, 1, 2'b10, 4);
    addVec(1, 1, 0, 2'b00, 0, 2'b01, 1);
    addVec(0, 1, 0, 2'b00, 0, 2'b01, 1);
    addVec(0, 1, 1, 2'b00, 0, 2'b01, 5);   // 6-cycle button starts in ASSERT
    addVec(0, 1, 1, 2'b01, 0, 2'b01, 1);
    addVec(0, 1, 0, 2'b01, 0, 2'b01, 1);
    addVec(0, 1, 0, 2'b00, 0, 2'b11, 1);   // debounced button hits RELEASE
    addVec(0, 1, 0, 2'b00, 0, 2'b11, 9);
    addVec(0, 1, 0, 2'b01, 0, 2'b11, 3);
    addVec(0, 1, 0, 2'b11, 1, 2'b11, 1);
    addVec(1, 1, 0, 2'b00, 0, 2'b01, 1);   // RESET in RUN
    addVec(0, 1, 0, 2'b00, 0, 2'b01, 6);
    addVec(0, 1, 0, 2'b01, 0, 2'b01, 1);
    addVec(1, 1, 0, 2'b00, 0, 2'b01, 1);   // RESET in RELEASE
    addVec(0, 1, 0, 2'b00, 0, 2'b01, 6);
    addVec(0, 1, 0, 2'b01, 0, 2'b01, 3);
    addVec(0, 1, 0, 2'b11, 1, 2'b01, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].lock, vecs[i].btn, 2'b00);
      checkOutput($sformatf("vec%0d", i), vecs[i].rstn, vecs[i].ready, vecs[i].cause);
    end

    // Soft reset of channel 1: low for exactly four cycles.
    for (int i = 0; i < 6; i++) begin
      sw = (i == 0) ? 2'b10 : 2'b00;
      applyStimulus(0, 1, 0, sw);
      low = SWEN && (i < 4);
      checkOutput($sformatf("soft_ch1_c%0d", i), low ? 2'b01 : 2'b11, !low, 2'b01);
    end

    // A repeat request two cycles in restarts the count.
    for (int i = 0; i < 8; i++) begin
      sw = (i == 0 || i == 2) ? 2'b10 : 2'b00;
      applyStimulus(0, 1, 0, sw);
      low = SWEN && (i < 6);
      checkOutput($sformatf("soft_restart_c%0d", i), low ? 2'b01 : 2'b11, !low, 2'b01);
    end

    // Soft reset of channel 0 leaves channel 1 untouched.
    for (int i = 0; i < 5; i++) begin
      sw = (i == 0) ? 2'b01 : 2'b00;
      applyStimulus(0, 1, 0, sw);
      low = SWEN && (i < 4);
      checkOutput($sformatf("soft_ch0_c%0d", i), low ? 2'b10 : 2'b11, !low, 2'b01);
    end

    // Soft requests alongside a lock drop: the synced loss wins and forces a full sequence.
    for (int i = 0; i < 11; i++) begin
      sw = (i == 0 || i == 2) ? 2'b01 : 2'b00;
      applyStimulus(0, (i == 0) ? 1'b0 : 1'b1, 0, sw);
      if (i < 2) begin
        low = SWEN;
        checkOutput($sformatf("soft_vs_lock_c%0d", i), low ? 2'b10 : 2'b11, !low, 2'b01);
      end else if (i < 7) begin
        checkOutput($sformatf("soft_vs_lock_c%0d", i), 2'b00, 1'b0, 2'b10);
      end else if (i < 10) begin
        checkOutput($sformatf("soft_vs_lock_c%0d", i), 2'b01, 1'b0, 2'b10);
      end else begin
        checkOutput($sformatf("soft_vs_lock_c%0d", i), 2'b11, 1'b1, 2'b10);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter NCH, default 2: number of reset domains, legal range 1..16.
REQ-002 SHALL have parameter HOLD_CYCLES, default 255: assert-hold count, minimum 1.
REQ-003 SHALL have parameter STAGGER, default 16: cycles between successive channel releases, minimum 1.
REQ-004 SHALL have parameter DEBOUNCE, default 1000: stable-cycle count for the button, minimum 1.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock.
REQ-006 SHALL have port RESET, input, 1 bit: synchronous, active-high master reset.
REQ-007 SHALL have port PLL_LOCKED, input, 1 bit: PLL lock, asynchronous to CLK.
REQ-008 SHALL have port BTN_RST, input, 1 bit: pushbutton reset request, asynchronous, active-high.
REQ-009 SHALL have port SW_RST_REQ, input, NCH bits: per-channel soft-reset request, synchronous.
REQ-010 SHALL have port RSTn, output, NCH bits: per-domain active-low resets.
REQ-011 SHALL have port READY, output, 1 bit: all domains out of reset.
REQ-012 SHALL have port CAUSE, output, 2 bits: cause of the last full reset.

Function
REQ-013 SHALL pass PLL_LOCKED and BTN_RST each through a 2-flop synchronizer; both flops reset to 0.
REQ-014 SHALL toggle the debounced button only after the synchronized BTN_RST differs from it for DEBOUNCE consecutive cycles; any mismatch break restarts the count.
REQ-015 SHALL implement states ASSERT, RELEASE and RUN.
REQ-016 ASSERT: all RSTn=0, READY=0; the hold counter decrements on each edge where synced lock=1 and the debounced button=0; at an edge with counter==0 -> RELEASE, RSTn[0]=1, stagger counter=STAGGER-1.
REQ-017 In ASSERT, a cycle with lock=0 or button=1 SHALL reload the hold counter to HOLD_CYCLES.
REQ-018 RELEASE: the stagger counter decrements each edge; at an edge with counter==0, release the next channel in ascending index order and reload to STAGGER-1; releasing channel NCH-1 -> RUN with READY=1 on the same edge.
REQ-019 With NCH=1 SHALL enter RUN, with RSTn[0]=1 and READY=1, on the same edge as leaving ASSERT.
REQ-020 In any state, synced lock=0 or debounced button=1 SHALL cause the next edge to enter ASSERT with all RSTn=0, READY=0 and the hold counter reloaded.
REQ-021 CAUSE SHALL update on entry to ASSERT with priority RESET=01, lock loss=10, button=11, and hold its value otherwise.

Reset
REQ-022 RESET=1 at an edge SHALL set state=ASSERT, RSTn=0, READY=0, CAUSE=01, hold counter=HOLD_CYCLES, synchronizers=0, debounced button=0, soft counters=0.
REQ-023 RESET asserted mid-RELEASE or mid-RUN SHALL take effect at that edge and override every other event.

Configuration
REQ-024 Macro RESET_SEQ_SWRST_EN SHALL compile in soft reset, per REQ-025 to REQ-027; without it, SW_RST_REQ is ignored and no soft counters exist.
REQ-025 In RUN, SW_RST_REQ[k]=1 at an edge SHALL drive RSTn[k]=0 from that edge for exactly HOLD_CYCLES cycles, then set RSTn[k]=1; other channels are unaffected.
REQ-026 A repeated request during an active soft reset SHALL restart that channel's count; requests outside RUN SHALL be ignored; READY=0 while any soft reset is active.
REQ-027 Lock loss or button on the same edge as a soft request SHALL win (full ASSERT, soft counters cleared).

Verification (NCH=2, HOLD_CYCLES=4, STAGGER=3, DEBOUNCE=5)
REQ-028 RESET released, PLL_LOCKED=1 first sampled at edge e -> RSTn[0] rises at e+6, RSTn[1] and READY rise at e+9, CAUSE=01.
REQ-029 PLL_LOCKED dropped for 1 cycle during RUN -> RSTn=00 and READY=0 two edges after sampling, CAUSE=10, full sequence repeats.
REQ-030 BTN_RST high for 4 cycles -> no effect; high for 6 cycles during RELEASE -> ASSERT, CAUSE=11.
REQ-031 With RESET_SEQ_SWRST_EN, SW_RST_REQ=10 pulsed in RUN -> RSTn[1]=0 for 4 cycles, RSTn[0]=1 throughout, READY=0 for those 4 cycles.
REQ-032 SW_RST_REQ pulsed in the same cycle PLL_LOCKED drops in RUN -> full ASSERT, CAUSE=10; without the macro, the pulse leaves RSTn=11.
